// File: rtl/triggers_pkg.sv
// Shared types for the triggers library: operation encoding for univ_reg.
// No logic; imported by the register datapath and its testbench.
package triggers_pkg;

  localparam int UNIV_MODE_W = 3;

  typedef enum logic [UNIV_MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_INV  = 3'b111
  } univ_mode_t;

endpackage

// File: rtl/dff_cell.sv
// Single-bit enabled D trigger with async active-high reset to a per-bit value.
// Latency 1 cycle; en=0 holds state, no backpressure.
module dff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= rst_val;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/univ_reg.sv
// WIDTH-bit universal register: hold/load/shift/rotate/clear/invert, true and complement outputs.
// Latency 1 cycle from sampled inputs to q; en=0 freezes q and sout, no backpressure.
module univ_reg
  import triggers_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [UNIV_MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]       d,
  input  logic                   sin,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       nq,
  output logic                   sout
);

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] shl_v, shr_v, rol_v, ror_v;
  logic             sout_nxt;

  // A 1-bit register has no neighbours: shifts take sin, rotates are identity.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shl_v = sin;
      assign shr_v = sin;
      assign rol_v = q;
      assign ror_v = q;
    end else begin : g_wn
      assign shl_v = {q[WIDTH-2:0], sin};
      assign shr_v = {sin, q[WIDTH-1:1]};
      assign rol_v = {q[WIDTH-2:0], q[WIDTH-1]};
      assign ror_v = {q[0], q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    q_nxt    = q;
    sout_nxt = sout;
    case (mode)
      MODE_HOLD: q_nxt = q;
      MODE_LOAD: q_nxt = d;
      MODE_SHL:  begin q_nxt = shl_v; sout_nxt = q[WIDTH-1]; end
      MODE_SHR:  begin q_nxt = shr_v; sout_nxt = q[0];       end
      MODE_ROL:  begin q_nxt = rol_v; sout_nxt = q[WIDTH-1]; end
      MODE_ROR:  begin q_nxt = ror_v; sout_nxt = q[0];       end
      MODE_CLR:  q_nxt = RESET_VAL;
      MODE_INV:  q_nxt = ~q;
      default:   q_nxt = q;
    endcase
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      dff_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RESET_VAL[i]),
        .en      (en),
        .d       (q_nxt[i]),
        .q       (q[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sout <= 1'b0;
    else if (en)
      sout <= sout_nxt;
  end

  // Complement straight off q so the pair can never disagree.
  assign nq = ~q;

  a_mode_known : assert property (@(posedge clk) disable iff (rst) en |-> !$isunknown(mode));

endmodule

// File: tb/tb_univ_reg.sv
// Directed bench for univ_reg: WIDTH=4/RESET_VAL=4'hA instance plus a WIDTH=1 instance.
module tb_univ_reg;
  import triggers_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, en1;
  logic [2:0] mode, mode1;
  logic [3:0] d;
  logic       d1;
  logic       sin, sin1;
  logic [3:0] q, nq;
  logic       sout;
  logic       q1, nq1, sout1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  univ_reg #(.WIDTH(4), .RESET_VAL(4'hA)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q), .nq(nq), .sout(sout)
  );

  univ_reg #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1), .d(d1), .sin(sin1),
    .q(q1), .nq(nq1), .sout(sout1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (q !== 4'hA)    begin n_fail++; $display("FAIL rst_async_q got %h want a", q); end
    n_cmp++; if (nq !== 4'h5)   begin n_fail++; $display("FAIL rst_async_nq got %h want 5", nq); end
    n_cmp++; if (sout !== 1'b0) begin n_fail++; $display("FAIL rst_async_sout got %b want 0", sout); end
    n_cmp++; if (q1 !== 1'b0 || nq1 !== 1'b1 || sout1 !== 1'b0)
      begin n_fail++; $display("FAIL rst_w1 got q=%b nq=%b sout=%b want 0 1 0", q1, nq1, sout1); end
    step();
    rst  = 1'b0;
    mode = MODE_HOLD;
    en   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (q !== 4'hA) begin n_fail++; $display("FAIL rst_hold[%0d] got %h want a", i, q); end
    end
  endtask

  task automatic test_load_enable();
    mode = MODE_LOAD; d = 4'h3; en = 1'b1;
    step();
    n_cmp++; if (q !== 4'h3 || nq !== 4'hC) begin n_fail++; $display("FAIL load got q=%h nq=%h want 3 c", q, nq); end
    d = 4'hF; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (q !== 4'h3) begin n_fail++; $display("FAIL en_hold[%0d] got %h want 3", i, q); end
    end
  endtask

  task automatic test_shift();
    en = 1'b1; mode = MODE_SHL; sin = 1'b1;
    step();
    n_cmp++; if (q !== 4'h7 || sout !== 1'b0) begin n_fail++; $display("FAIL shl1 got q=%h sout=%b want 7 0", q, sout); end
    sin = 1'b0;
    step();
    n_cmp++; if (q !== 4'hE) begin n_fail++; $display("FAIL shl0 got %h want e", q); end
    mode = MODE_SHR; sin = 1'b1;
    step();
    n_cmp++; if (q !== 4'hF || sout !== 1'b0) begin n_fail++; $display("FAIL shr1 got q=%h sout=%b want f 0", q, sout); end
    sin = 1'b0;
    step();
    n_cmp++; if (q !== 4'h7 || sout !== 1'b1) begin n_fail++; $display("FAIL shr0 got q=%h sout=%b want 7 1", q, sout); end
    mode = MODE_SHL; sin = 1'b1; en = 1'b0;
    step();
    n_cmp++; if (q !== 4'h7 || sout !== 1'b1) begin n_fail++; $display("FAIL shl_dis got q=%h sout=%b want 7 1", q, sout); end
  endtask

  task automatic test_rotate();
    en = 1'b1; mode = MODE_LOAD; d = 4'h9;
    step();
    mode = MODE_ROL;
    step();
    n_cmp++; if (q !== 4'h3 || sout !== 1'b1) begin n_fail++; $display("FAIL rol got q=%h sout=%b want 3 1", q, sout); end
    mode = MODE_ROR;
    step();
    n_cmp++; if (q !== 4'h9 || sout !== 1'b1) begin n_fail++; $display("FAIL ror got q=%h sout=%b want 9 1", q, sout); end
    mode = MODE_ROL;
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (q !== 4'h9) begin n_fail++; $display("FAIL rol4 got %h want 9", q); end
  endtask

  task automatic test_clr_inv();
    en = 1'b1; mode = MODE_LOAD; d = 4'h6;
    step();
    mode = MODE_INV;
    step();
    n_cmp++; if (q !== 4'h9 || nq !== 4'h6) begin n_fail++; $display("FAIL inv got q=%h nq=%h want 9 6", q, nq); end
    n_cmp++; if (sout !== 1'b1) begin n_fail++; $display("FAIL inv_sout_hold got %b want 1", sout); end
    mode = MODE_CLR;
    step();
    n_cmp++; if (q !== 4'hA) begin n_fail++; $display("FAIL clr got %h want a", q); end
    mode = MODE_LOAD; d = 4'h5;
    step();
    mode = MODE_SHL; sin = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (q !== 4'hA || sout !== 1'b0) begin n_fail++; $display("FAIL rst_mid got q=%h sout=%b want a 0", q, sout); end
    step();
    n_cmp++; if (q !== 4'hA) begin n_fail++; $display("FAIL rst_edge got %h want a", q); end
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_width1();
    en1 = 1'b1; mode1 = MODE_SHL; sin1 = 1'b1;
    step();
    n_cmp++; if (q1 !== 1'b1 || sout1 !== 1'b0) begin n_fail++; $display("FAIL w1_shl got q=%b sout=%b want 1 0", q1, sout1); end
    mode1 = MODE_ROL;
    step();
    n_cmp++; if (q1 !== 1'b1 || sout1 !== 1'b1) begin n_fail++; $display("FAIL w1_rol got q=%b sout=%b want 1 1", q1, sout1); end
    mode1 = MODE_INV;
    step();
    n_cmp++; if (q1 !== 1'b0 || nq1 !== 1'b1) begin n_fail++; $display("FAIL w1_inv got q=%b nq=%b want 0 1", q1, nq1); end
    mode1 = MODE_ROR;
    step();
    n_cmp++; if (q1 !== 1'b0 || sout1 !== 1'b0) begin n_fail++; $display("FAIL w1_ror got q=%b sout=%b want 0 0", q1, sout1); end
    mode1 = MODE_LOAD; d1 = 1'b1;
    step();
    mode1 = MODE_SHR; sin1 = 1'b0;
    step();
    n_cmp++; if (q1 !== 1'b0 || sout1 !== 1'b1) begin n_fail++; $display("FAIL w1_shr got q=%b sout=%b want 0 1", q1, sout1); end
    en1 = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = MODE_HOLD; d = '0; sin = 1'b0;
    en1 = 1'b0; mode1 = MODE_HOLD; d1 = 1'b0; sin1 = 1'b0;
    test_reset();
    test_load_enable();
    test_shift();
    test_rotate();
    test_clr_inv();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
